// File: rtl/fp_mult_if.sv
// Operand/result stream bundle for the pipelined floating-point multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface fp_mult_if #(
  parameter int unsigned W = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754 multiplier: classify/exponent, significand product, normalise/round/pack.
// Round-to-nearest-even, subnormals flushed to zero, flags {invalid, overflow, underflow, inexact}.
module fp_mult_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic     clk,
  input  logic     rst_n,
  fp_mult_if.slave bus
);
  localparam int unsigned W  = EXP_W + MAN_W + 1;
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned XW = EXP_W + 2;

  localparam logic signed [XW-1:0] Bias   = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] ExpMax = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNaN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  // Whole pipeline freezes while the output register holds an unaccepted result.
  logic adv;
  assign adv          = ~(out_valid_q & ~bus.out_ready);
  assign bus.in_ready = adv;

  // ---------------- Stage 1: unpack, classify, exponent sum ----------------
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {a_s, a_e, a_f} = bus.in_a;
  assign {b_s, b_e, b_f} = bus.in_b;
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (&a_e) & (a_f == '0);
  assign b_inf  = (&b_e) & (b_f == '0);
  assign a_nan  = (&a_e) & (|a_f);
  assign b_nan  = (&b_e) & (|b_f);

  logic                 v1_d, v1_q, sign1_d, sign1_q, spec1_d, spec1_q;
  logic signed [XW-1:0] exp1_d, exp1_q;
  logic [SW-1:0]        sa1_d, sa1_q, sb1_d, sb1_q;
  logic [W-1:0]         sres1_d, sres1_q;
  logic [3:0]           sflg1_d, sflg1_q;

  always_comb begin
    v1_d    = bus.in_valid;
    sign1_d = a_s ^ b_s;
    exp1_d  = $signed({2'b00, a_e}) + $signed({2'b00, b_e}) - Bias;
    sa1_d   = {1'b1, a_f};
    sb1_d   = {1'b1, b_f};
    spec1_d = 1'b0;
    sres1_d = '0;
    sflg1_d = '0;
    // Special operands resolve here; zero class includes subnormals.
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      spec1_d = 1'b1;
      sres1_d = QNaN;
      sflg1_d = 4'b1000;
    end else if (a_inf | b_inf) begin
      spec1_d = 1'b1;
      sres1_d = {sign1_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      spec1_d = 1'b1;
      sres1_d = {sign1_d, {(W - 1){1'b0}}};
    end
  end

  // ---------------- Stage 2: significand product ----------------
  logic                 v2_q, sign2_q, spec2_q;
  logic signed [XW-1:0] exp2_q;
  logic [PW-1:0]        prod2_d, prod2_q;
  logic [W-1:0]         sres2_q;
  logic [3:0]           sflg2_q;

  assign prod2_d = PW'(sa1_q) * PW'(sb1_q);

  // ---------------- Stage 3: normalise, round, pack ----------------
  logic [PW-1:0]        p_n;
  logic signed [XW-1:0] e_n, e_r;
  logic [MAN_W-1:0]     frac_n;
  logic [MAN_W:0]       frac_r;
  logic                 guard, sticky;
  logic                 out_valid_d, out_valid_q;
  logic [W-1:0]         out_res_d, out_res_q;
  logic [3:0]           out_flags_d, out_flags_q;

  always_comb begin
    p_n    = prod2_q[PW-1] ? prod2_q : (prod2_q << 1);
    e_n    = exp2_q + {{(XW - 1){1'b0}}, prod2_q[PW-1]};
    frac_n = p_n[PW-2 -: MAN_W];
    guard  = p_n[MAN_W];
    sticky = |p_n[MAN_W-1:0];
    frac_r = {1'b0, frac_n} + {{MAN_W{1'b0}}, guard & (sticky | frac_n[0])};
    // A rounding carry leaves frac_r[MAN_W-1:0] at zero, so only the exponent moves.
    e_r    = e_n + {{(XW - 1){1'b0}}, frac_r[MAN_W]};

    out_valid_d = v2_q;
    out_res_d   = {sign2_q, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
    out_flags_d = {3'b000, guard | sticky};
    if (spec2_q) begin
      out_res_d   = sres2_q;
      out_flags_d = sflg2_q;
    end else if (e_n[XW-1] || (e_n == '0)) begin
      out_res_d   = {sign2_q, {(W - 1){1'b0}}};
      out_flags_d = 4'b0011;
    end else if (e_r >= ExpMax) begin
      out_res_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_flags_d = 4'b0101;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      spec1_q     <= 1'b0;
      exp1_q      <= '0;
      sa1_q       <= '0;
      sb1_q       <= '0;
      sres1_q     <= '0;
      sflg1_q     <= '0;
      v2_q        <= 1'b0;
      sign2_q     <= 1'b0;
      spec2_q     <= 1'b0;
      exp2_q      <= '0;
      prod2_q     <= '0;
      sres2_q     <= '0;
      sflg2_q     <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      v1_q        <= v1_d;
      sign1_q     <= sign1_d;
      spec1_q     <= spec1_d;
      exp1_q      <= exp1_d;
      sa1_q       <= sa1_d;
      sb1_q       <= sb1_d;
      sres1_q     <= sres1_d;
      sflg1_q     <= sflg1_d;
      v2_q        <= v1_q;
      sign2_q     <= sign1_q;
      spec2_q     <= spec1_q;
      exp2_q      <= exp1_q;
      prod2_q     <= prod2_d;
      sres2_q     <= sres1_q;
      sflg2_q     <= sflg1_q;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_flags = out_flags_q;
endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point multiplier with a valid/ready stream interface.
- Successor to the combinational single-precision multiplier. Adds generic exponent and mantissa widths, round-to-nearest-even, special-value handling, exception flags and backpressure.
- Sits between operand-issue logic and the result writeback stream.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- W, EXP_W+MAN_W+1, total operand width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  W  operand A {sign, exp, frac}.
- in_b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_res  out  W  packed product.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all stage valid bits 0. out_valid=0, out_res=0, out_flags=0. in_ready=1 once reset deasserts.
- Reset mid-operation discards all in-flight operations; no partial result is emitted.
- Pipeline: 3 stages, latency 3 cycles from accepted input to out_valid when unstalled. Throughput 1 per cycle.
- S1: unpack fields, classify operands (zero, inf, NaN, normal), compute sign = a.s XOR b.s, compute biased exponent sum ea+eb-bias in EXP_W+2 signed bits.
- S2: (MAN_W+1)x(MAN_W+1) unsigned product of the significands with hidden bits → 2*MAN_W+2 bits.
- S3: normalise, round, pack, flags.
  - If product MSB=1: shift right 1 and exp+1.
  - Guard bit = first dropped bit; sticky = OR of remaining dropped bits.
  - RNE: increment if guard & (sticky | lsb). Rounding carry-out renormalises: frac=0, exp+1.
- Handshake: stall = out_valid & ~out_ready; in_ready = ~stall.
  - When stalled, all stages hold; out_res and out_flags stay stable.
  - Transfer on in_valid & in_ready.
  - Bubbles are not compressed.
- Subnormal inputs are treated as signed zero (no flag).
- Special cases, evaluated in priority order:
  - Any NaN, or inf x zero → canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0), invalid=1.
  - Inf x finite nonzero, or inf x inf → signed inf, no flags.
  - Zero x finite → signed zero, no flags.
- Overflow: final exp ≥ 2^EXP_W-1 → signed inf, overflow=1, inexact=1.
- Underflow: exp before rounding ≤ 0 → flush to signed zero, underflow=1, inexact=1 (no subnormal output).
- inexact=1 whenever guard|sticky is nonzero for a normal result.
- Flags accompany their result and are not sticky across results.

Test Plan:
- Normal path: 0x3FC00000 x 0x40000000 → 0x40400000 flags 0000. Then 0xC0000000 x 0x40400000 → 0xC0C00000 flags 0000. Both on consecutive cycles; outputs appear 3 cycles later, back to back.
- Rounding:
  - 0x3F800001 x 0x3F800001 → 0x3F800002 flags 0001.
  - Tie-to-even: 0x3F800001 x 0x3FC00000 → 0x3FC00002 flags 0001.
- Exceptions:
  - 0x7F000000 x 0x7F000000 → 0x7F800000 flags 0101.
  - 0x00800000 x 0x00800000 → 0x00000000 flags 0011.
  - 0x7F800000 x 0x00000000 → 0x7FC00000 flags 1000.
  - 0xFF800000 x 0x40000000 → 0xFF800000 flags 0000.
- Backpressure:
  - Stream 6 operations with out_ready low for cycles 4-7.
  - in_ready must drop while out_valid & ~out_ready.
  - No result is lost or duplicated; order is preserved; out_res is stable during the stall.
- Reset mid-flight: assert rst_n=0 asynchronously with 3 operations in flight → out_valid=0 immediately; after release no stale result appears.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision). 0x3E00 x 0x4000 → 0x4200, 0x7BFF x 0x4000 → 0x7C00 flags 0101. Random compare against a reference model over 10k vectors per configuration.
